// File: rtl/sevenseg_scan.sv
// Scanning driver for a four-digit common-anode seven-segment display.
// Each digit slot opens with a dark guard interval to prevent ghosting.
module sevenseg_scan #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   snapValue_q, snapValue_d;
  logic [3:0]    snapDp_q, snapDp_d;
  logic [3:0]    snapBlank_q, snapBlank_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic [3:0]    nibble;

  function automatic logic [6:0] decodeHex(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h7F;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_comb begin
    cnt_d       = cnt_q + 1'b1;
    idx_d       = idx_q;
    snapValue_d = snapValue_q;
    snapDp_d    = snapDp_q;
    snapBlank_d = snapBlank_q;
    seg_d       = 7'h7F;
    dp_d        = 1'b1;
    an_d        = 4'hF;
    nibble      = snapValue_q[{idx_q, 2'b00} +: 4];

    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end

    // Inputs are captured once per full scan so all four digits agree.
    if (cnt_q == '0 && idx_q == 2'd0) begin
      snapValue_d = value;
      snapDp_d    = dp_in;
      snapBlank_d = blank;
    end

    if (cnt_q >= CNT_BLANK && !snapBlank_q[idx_q]) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = decodeHex(nibble);
      dp_d  = ~snapDp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      snapValue_q <= 16'h0000;
      snapDp_q    <= 4'h0;
      snapBlank_q <= 4'h0;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
      an_q        <= 4'hF;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      snapValue_q <= snapValue_d;
      snapDp_q    <= snapDp_d;
      snapBlank_q <= snapBlank_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan: expected pins are derived from the cycle number
// since reset release, using the slot/scan arithmetic of the display timing.
module tb_sevenseg_scan;

  localparam int DIV   = 8;
  localparam int BLANK = 2;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int total;
  int bad;

  // Reference state: cycle number since release plus the captured inputs.
  int         t;
  logic [15:0] refValue;
  logic [3:0]  refDp;
  logic [3:0]  refBlank;
  logic [6:0]  expSeg;
  logic        expDp;
  logic [3:0]  expAn;
  logic [6:0]  segTab [16];

  sevenseg_scan #(
    .REFRESH_DIV (DIV),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .value(value),
    .dp_in(dp_in),
    .blank(blank),
    .seg  (seg),
    .dp   (dp),
    .an   (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Predict the pins after the coming edge, advance the reference, then compare.
  task automatic applyStimulus();
    int slot;
    int digit;
    if (rst) begin
      expAn    = 4'hF;
      expSeg   = 7'h7F;
      expDp    = 1'b1;
      refValue = 16'h0000;
      refDp    = 4'h0;
      refBlank = 4'h0;
      t        = 0;
    end else begin
      slot  = t % DIV;
      digit = (t / DIV) % 4;
      if (slot < BLANK || refBlank[digit]) begin
        expAn  = 4'hF;
        expSeg = 7'h7F;
        expDp  = 1'b1;
      end else begin
        expAn  = 4'hF & ~(4'(1) << digit);
        expSeg = segTab[(refValue >> (4 * digit)) & 16'hF];
        expDp  = ~refDp[digit];
      end
      if (t % (4 * DIV) == 0) begin
        refValue = value;
        refDp    = dp_in;
        refBlank = blank;
      end
      t = t + 1;
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic checkOutput();
    total++;
    assert (an === expAn) else begin
      bad++;
      $error("[TB] FAIL an t=%0d observed=%b expected=%b", t, an, expAn);
    end
    total++;
    assert (seg === expSeg) else begin
      bad++;
      $error("[TB] FAIL seg t=%0d observed=%h expected=%h", t, seg, expSeg);
    end
    total++;
    assert (dp === expDp) else begin
      bad++;
      $error("[TB] FAIL dp t=%0d observed=%b expected=%b", t, dp, expDp);
    end
    total++;
    assert ($countones(~an) <= 1) else begin
      bad++;
      $error("[TB] FAIL anOneHot t=%0d observed=%b expected=at most one low", t, an);
    end
  endtask

  task automatic runCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus();
  endtask

  task automatic pulseReset(input int n);
    rst = 1'b1;
    runCycles(n);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] sweep [4];
    total  = 0;
    bad    = 0;
    t      = 0;
    segTab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    sweep  = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
    rst    = 1'b1;
    value  = 16'h1234;
    dp_in  = 4'h0;
    blank  = 4'h0;

    $display("[TB] reset and first digit");
    pulseReset(3);
    runCycles(12);

    $display("[TB] full scan ABCD");
    value = 16'hABCD;
    pulseReset(1);
    runCycles(64);

    $display("[TB] snapshot isolation");
    value = 16'h1234;
    pulseReset(1);
    runCycles(10);
    value = 16'h5678;
    runCycles(30);

    $display("[TB] blank and dp masks");
    value = 16'h0000;
    blank = 4'b1000;
    dp_in = 4'b0001;
    pulseReset(1);
    runCycles(40);
    blank = 4'h0;
    dp_in = 4'h0;

    $display("[TB] reset mid-scan");
    value = 16'h9E5C;
    pulseReset(1);
    runCycles(13);
    pulseReset(1);
    runCycles(16);

    $display("[TB] decode sweep");
    pulseReset(1);
    for (int v = 0; v < 4; v++) begin
      value = sweep[v];
      runCycles(4 * DIV);
    end
    runCycles(4 * DIV);

    $display("[TB] random inputs");
    pulseReset(1);
    for (int c = 0; c < 320; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        value = 16'($urandom);
        dp_in = 4'($urandom);
        blank = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
      end
      rst = ($urandom_range(0, 99) == 0);
      applyStimulus();
    end
    rst = 1'b0;
    runCycles(4 * DIV);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
